// File: rtl/spi_flash_slave.sv
// spi_flash_slave: SPI NOR flash responder (SPI mode 0, oversampled on i_clk)
// serving WREN/WRDI/RDSR/READ/PP/SE from an internal byte array.
// Ports:
//   i_clk, i_rst          system clock, synchronous active-high reset
//   i_spi_clk/cs/mosi     asynchronous SPI inputs (2-FF synchronized)
//   o_spi_miso            registered slave-out data
//   o_busy                WIP: reset sweep or sector erase in progress
//   o_status              status register {6'b0, WEL, WIP}
module spi_flash_slave #(
   parameter int unsigned P_MEM_AW    = 13,
   parameter int unsigned P_PAGE_AW   = 8,
   parameter int unsigned P_SECTOR_AW = 12
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_spi_clk,
   input  logic       i_spi_cs,
   input  logic       i_spi_mosi,
   output logic       o_spi_miso,
   output logic       o_busy,
   output logic [7:0] o_status
);

   localparam logic [7:0] C_WREN = 8'h06;
   localparam logic [7:0] C_WRDI = 8'h04;
   localparam logic [7:0] C_RDSR = 8'h05;
   localparam logic [7:0] C_READ = 8'h03;
   localparam logic [7:0] C_PP   = 8'h02;
   localparam logic [7:0] C_SE   = 8'h20;

   localparam logic [P_MEM_AW-1:0] L_PAGE_LOW  = P_MEM_AW'((64'd1 << P_PAGE_AW) - 64'd1);
   localparam logic [P_MEM_AW-1:0] L_SEC_LOW   = P_MEM_AW'((64'd1 << P_SECTOR_AW) - 64'd1);
   localparam logic [P_MEM_AW:0]   L_SEC_BYTES = (P_MEM_AW+1)'(64'd1 << P_SECTOR_AW);
   localparam logic [P_MEM_AW:0]   L_MEM_BYTES = (P_MEM_AW+1)'(64'd1 << P_MEM_AW);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_RDATA, S_WDATA, S_STAT, S_IGNORE, S_ERASE
   } state_t;

   state_t                state_q, state_d;
   logic [2:0]            sck_sync_q, cs_sync_q;
   logic [1:0]            mosi_sync_q;
   logic [2:0]            bit_cnt_q, bit_cnt_d;
   logic [6:0]            shift_q, shift_d;
   logic [P_MEM_AW-1:0]   addr_q, addr_d;
   logic [1:0]            addr_cnt_q, addr_cnt_d;
   logic [7:0]            cmd_q, cmd_d;
   logic                  wel_q, wel_d;
   logic                  se_arm_q, se_arm_d;
   logic [6:0]            tx_q, tx_d;
   logic                  miso_q, miso_d;
   logic [P_MEM_AW-1:0]   sweep_addr_q, sweep_addr_d;
   logic [P_MEM_AW:0]     sweep_left_q, sweep_left_d;
   logic                  wr_pend_q, wr_pend_d;
   logic [P_MEM_AW-1:0]   wr_addr_q, wr_addr_d;
   logic [7:0]            wr_data_q, wr_data_d;

   logic [7:0]            mem_q [0:(1<<P_MEM_AW)-1];
   logic [7:0]            rdata_q;
   logic                  rd_en;
   logic [P_MEM_AW-1:0]   rd_addr;
   logic                  mem_we;
   logic [P_MEM_AW-1:0]   mem_wa;
   logic [7:0]            mem_wd;

   logic                  sck_rise, sck_fall, cs_n, cs_fall, cs_rise, mosi;
   logic                  wip, byte_done;
   logic [7:0]            rx_byte, status, tx_src;
   logic [P_MEM_AW-1:0]   addr_next;

   assign sck_rise  = sck_sync_q[1] & ~sck_sync_q[2];
   assign sck_fall  = ~sck_sync_q[1] & sck_sync_q[2];
   assign cs_n      = cs_sync_q[1];
   assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
   assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
   assign mosi      = mosi_sync_q[1];
   assign wip       = (sweep_left_q != '0);
   assign status    = {6'b0, wel_q, wip};
   assign rx_byte   = {shift_q, mosi};
   assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
   assign addr_next = {addr_q[P_MEM_AW-2:0], mosi};

   // Single port: the sweep owns it while WIP; a PP byte is a read-modify-write
   // whose write lands one cycle after its read (AND keeps NOR 1->0 semantics).
   assign mem_we = !i_rst && (wip || wr_pend_q);
   assign mem_wa = wip ? sweep_addr_q : wr_addr_q;
   assign mem_wd = wip ? 8'hFF : (rdata_q & wr_data_q);

   always_ff @(posedge i_clk) begin
      if (mem_we) mem_q[mem_wa] <= mem_wd;
      if (rd_en)  rdata_q <= mem_q[rd_addr];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= S_IDLE;
         sck_sync_q   <= '0;
         cs_sync_q    <= '1;
         mosi_sync_q  <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         addr_q       <= '0;
         addr_cnt_q   <= '0;
         cmd_q        <= '0;
         wel_q        <= 1'b0;
         se_arm_q     <= 1'b0;
         tx_q         <= '0;
         miso_q       <= 1'b0;
         sweep_addr_q <= '0;
         sweep_left_q <= L_MEM_BYTES;
         wr_pend_q    <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         sck_sync_q   <= {sck_sync_q[1:0], i_spi_clk};
         cs_sync_q    <= {cs_sync_q[1:0], i_spi_cs};
         mosi_sync_q  <= {mosi_sync_q[0], i_spi_mosi};
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         addr_q       <= addr_d;
         addr_cnt_q   <= addr_cnt_d;
         cmd_q        <= cmd_d;
         wel_q        <= wel_d;
         se_arm_q     <= se_arm_d;
         tx_q         <= tx_d;
         miso_q       <= miso_d;
         sweep_addr_q <= sweep_addr_d;
         sweep_left_q <= sweep_left_d;
         wr_pend_q    <= wr_pend_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      addr_d       = addr_q;
      addr_cnt_d   = addr_cnt_q;
      cmd_d        = cmd_q;
      wel_d        = wel_q;
      se_arm_d     = se_arm_q;
      tx_d         = tx_q;
      miso_d       = miso_q;
      sweep_addr_d = sweep_addr_q;
      sweep_left_d = sweep_left_q;
      wr_pend_d    = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      rd_en        = 1'b0;
      rd_addr      = addr_q;
      tx_src       = (state_q == S_STAT) ? status : rdata_q;

      if (wip) begin
         sweep_addr_d = sweep_addr_q + P_MEM_AW'(1);
         sweep_left_d = sweep_left_q - (P_MEM_AW+1)'(1);
         if (sweep_left_q == (P_MEM_AW+1)'(1)) wel_d = 1'b0;
      end
      if (state_q == S_ERASE && !wip) state_d = S_IDLE;

      if (cs_fall) begin
         state_d   = S_CMD;
         bit_cnt_d = '0;
         cmd_d     = '0;
         se_arm_d  = 1'b0;
      end else if (cs_rise) begin
         state_d = S_IDLE;
         case (cmd_q)
            C_WREN:  wel_d = 1'b1;
            C_WRDI:  wel_d = 1'b0;
            C_PP:    wel_d = 1'b0;
            default: ;
         endcase
         // se_arm_q only survives when CS rises before any 33rd SCK edge.
         if (se_arm_q) begin
            state_d      = S_ERASE;
            sweep_addr_d = addr_q & ~L_SEC_LOW;
            sweep_left_d = L_SEC_BYTES;
         end
      end else if (!cs_n && sck_rise) begin
         bit_cnt_d = bit_cnt_q + 3'd1;
         shift_d   = rx_byte[6:0];
         se_arm_d  = 1'b0;
         case (state_q)
            S_CMD: if (byte_done) begin
               state_d    = S_IGNORE;
               addr_cnt_d = '0;
               if (rx_byte == C_RDSR) begin
                  state_d = S_STAT;
               end else if (!wip) begin
                  case (rx_byte)
                     C_WREN, C_WRDI:     cmd_d = rx_byte;
                     C_READ, C_PP, C_SE: begin cmd_d = rx_byte; state_d = S_ADDR; end
                     default: ;
                  endcase
               end
            end
            S_ADDR: begin
               addr_d = addr_next;
               if (byte_done) begin
                  addr_cnt_d = addr_cnt_q + 2'd1;
                  if (addr_cnt_q == 2'd2) begin
                     case (cmd_q)
                        C_READ: begin
                           rd_en   = 1'b1;
                           rd_addr = addr_next;
                           addr_d  = addr_next + P_MEM_AW'(1);
                           state_d = S_RDATA;
                        end
                        C_PP:    state_d = wel_q ? S_WDATA : S_IGNORE;
                        default: begin se_arm_d = wel_q; state_d = S_IGNORE; end
                     endcase
                  end
               end
            end
            S_RDATA: if (byte_done) begin
               rd_en  = 1'b1;
               addr_d = addr_q + P_MEM_AW'(1);
            end
            S_WDATA: if (byte_done) begin
               rd_en     = 1'b1;
               wr_pend_d = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = rx_byte;
               addr_d    = (addr_q & ~L_PAGE_LOW) | ((addr_q + P_MEM_AW'(1)) & L_PAGE_LOW);
            end
            default: ;
         endcase
      end

      if (cs_n || !(state_q == S_RDATA || state_q == S_STAT)) begin
         miso_d = 1'b0;
      end else if (sck_fall) begin
         if (bit_cnt_q == 3'd0) begin
            miso_d = tx_src[7];
            tx_d   = tx_src[6:0];
         end else begin
            miso_d = tx_q[6];
            tx_d   = {tx_q[5:0], 1'b0};
         end
      end
   end

   assign o_spi_miso = miso_q;
   assign o_busy     = wip;
   assign o_status   = status;

endmodule

// File: doc/spi_flash_slave.md
# spi_flash_slave

Behavioural-but-synthesizable SPI NOR flash responder: the device end of the link driven by our SPI flash master. It oversamples SPI mode 0 (CPOL=0, CPHA=0) on the system clock, decodes a subset of standard flash commands and serves them from an internal byte array. It is used as an on-chip flash stand-in for loopback testing of the flash driver path on FPGA and in simulation.

## Interface
- P_MEM_AW, 13, byte address width of internal array (depth 2^P_MEM_AW); higher address bits ignored
- P_PAGE_AW, 8, page size 2^P_PAGE_AW bytes (program wrap boundary)
- P_SECTOR_AW, 12, sector size 2^P_SECTOR_AW bytes (erase unit); must be ≤ P_MEM_AW
- i_clk  in  1  system clock; the block has one clock
- i_rst  in  1  reset, synchronous, active-high
- i_spi_clk  in  1  SPI clock from master, asynchronous, 2-FF synchronized
- i_spi_cs  in  1  chip select, active-low, 2-FF synchronized
- i_spi_mosi  in  1  master-out data, 2-FF synchronized
- o_spi_miso  out  1  slave-out data, registered
- o_busy  out  1  status WIP bit (reset sweep or sector erase in progress)
- o_status  out  8  status register {6'b0, WEL, WIP}

## Operation
- Bit order MSB first. Rising SCK edge (synchronized): sample MOSI. Falling SCK edge: shift next MISO bit.
- CS falling edge: bit/byte counters cleared, enter CMD. CS rising edge: any state → IDLE (or ERASE if a valid SE was just completed); partial bytes discarded; WEL cleared if the transaction was a PP or SE with WEL set.
- States: IDLE, CMD, ADDR, RDATA, WDATA, STAT, IGNORE, ERASE.
- CMD: after 8 bits decode:
  - 0x06 WREN → WEL=1 at CS rise, then IGNORE.
  - 0x04 WRDI → WEL=0 at CS rise, then IGNORE.
  - 0x05 RDSR → STAT: o_status byte streamed repeatedly, re-latched at each byte boundary.
  - 0x03 READ → ADDR (24 bits), then RDATA.
  - 0x02 PP → ADDR, then WDATA if WEL=1, else IGNORE.
  - 0x20 SE → ADDR, then erase armed if WEL=1 and CS rises exactly after bit 32.
  - Any other → IGNORE until CS high.
- While WIP=1, every command except RDSR → IGNORE (WREN included).
- RDATA: byte at addr fetched on the 32nd rising edge; subsequent bytes prefetched on each byte's 8th rising edge; addr increments, wraps at 2^P_MEM_AW.
- WDATA: each completed byte written as mem[a] <= mem[a] & data (NOR: 1→0 only); the low P_PAGE_AW bits increment and wrap within the page, upper bits fixed. No length limit; bytes beyond one page overwrite (AND) earlier locations.
- ERASE: sets WIP, writes 0xFF to one byte per i_clk across the addressed sector (addr low P_SECTOR_AW bits forced to 0), 2^P_SECTOR_AW cycles, then WIP=0, WEL=0.
- MISO driven 0 whenever CS high or state is not RDATA/STAT.

## Timing
- Input sync latency 2 i_clk + 1 for edge detect. Requirement: each SCK high and low phase ≥ 4 i_clk; CS setup to first SCK rise ≥ 4 i_clk.
- First response bit (bit 7 of data/status) appears on MISO within 4 i_clk after the falling SCK edge following the last command/address bit, so it is valid before the next rising edge.
- Memory: synchronous read, 1 cycle latency; single port; erase/reset sweep owns the port, but SPI accesses cannot occur concurrently because commands are ignored while WIP=1.
- Reset: o_spi_miso=0, o_status=0x01, o_busy=1, state=IDLE; a full-array sweep writes 0xFF over all 2^P_MEM_AW bytes (one per cycle), then WIP=0. o_busy falls exactly 2^P_MEM_AW cycles after reset deassert.
- Reset asserted mid-transaction or mid-erase: immediate abort, sweep restarts from address 0.
- CS toggled during ERASE: erase continues; RDSR is served normally.

## Test plan
- Reset, poll RDSR: 0x01 during the first 8192 cycles, then 0x00; READ 0x000000 for 4 bytes → FF FF FF FF.
- WREN, RDSR → 0x02; PP 0x000010 with A5 3C; RDSR → 0x00; READ 0x000010 for 2 bytes → A5 3C; READ 0x002010 → A5 (P_MEM_AW alias).
- PP 0x000020 with 0x55 without WREN → READ → FF. With WREN, PP 0x0F then PP 0xF0 at the same address → READ → 0x00.
- Page wrap: WREN, PP 0x0001FF with 11 22 → READ 0x0001FF → 11, READ 0x000100 → 22, 0x000200 stays FF.
- WREN, SE 0x001234: o_busy high for 4096 cycles; a READ issued during busy returns MISO 0; afterwards 0x001000–0x001FFF = FF and prior data at 0x000010 unchanged. SE with CS rising at bit 30 → no erase, WEL still 1.
- Abort: CS rises after 5 bits of a READ command, then a full RDSR → 0x00; reset pulse during an erase → sweep restarts, o_busy high for 8192 cycles.
